// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and frame length, common to the tx and rx blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int FRAME_BITS = 11;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter. Power-of-two depth, so the pointers wrap for free.
module uart_tx_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  head,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;

  // The caller never pushes when full without popping, nor pops when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fpga.sv
// UART transmitter with input FIFO: 8 data bits LSB first, even parity, one stop bit.
module uart_tx_fpga
  import uart_pkg::*;
#(
  parameter int clksPerBit = 234,
  parameter int fifoDepth  = 4
) (
  input  logic                       i_clkTx,
  input  logic                       i_resetN,
  input  logic                       i_txValid,
  input  logic [7:0]                 i_txByte,
  output logic                       o_txReady,
  output logic                       o_txBit,
  output logic                       o_txActive,
  output logic                       o_txDone,
  output logic [$clog2(fifoDepth):0] o_fifoCount
);

  localparam logic [7:0] CNT_MAX = 8'(clksPerBit - 1);

  uart_state_e state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n;
  logic        par, par_n;
  logic        bit_q, bit_n;
  logic        bit_end, pop, push, full, empty;
  logic [7:0]  head;

  assign bit_end    = cnt == CNT_MAX;
  // Popping on the last stop cycle chains frames back to back with no idle gap.
  assign pop        = !empty && (state == IDLE || (state == STOP && bit_end));
  assign push       = i_txValid && o_txReady;
  assign o_txReady  = !full || pop;
  assign o_txDone   = state == STOP && bit_end;
  assign o_txActive = state != IDLE;
  assign o_txBit    = bit_q;

  uart_tx_fifo #(.DEPTH(fifoDepth)) u_fifo (
    .clk   (i_clkTx),
    .rst_n (i_resetN),
    .push  (push),
    .pop   (pop),
    .wdata (i_txByte),
    .head  (head),
    .count (o_fifoCount),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clkTx or negedge i_resetN) begin
    if (!i_resetN) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      bit_q <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      par   <= par_n;
      bit_q <= bit_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    bit_n   = bit_q;
    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 8'd1;
    case (state)
      IDLE: ;
      START:
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
          bit_n   = sh[0];
          sh_n    = sh >> 1;
        end
      DATA:
        if (bit_end) begin
          if (idx == 3'd7) begin
            state_n = PARITY;
            bit_n   = par;
          end else begin
            idx_n = idx + 3'd1;
            bit_n = sh[0];
            sh_n  = sh >> 1;
          end
        end
      PARITY:
        if (bit_end) begin
          state_n = STOP;
          bit_n   = 1'b1;
        end
      STOP:
        if (bit_end) begin
          state_n = IDLE;
          bit_n   = 1'b1;
        end
      default: state_n = IDLE;
    endcase
    // Parity is latched with the byte so later FIFO writes cannot disturb it.
    if (pop) begin
      state_n = START;
      cnt_n   = '0;
      idx_n   = '0;
      sh_n    = head;
      par_n   = even_parity(head);
      bit_n   = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fpga.sv
// Randomized bench for uart_tx_fpga against a frame-level model plus a line-sampling receiver.
module tb_uart_tx_fpga;
  import uart_pkg::*;

  localparam int CPB       = 4;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready, tx_bit, tx_active, tx_done;
  logic [2:0] fifo_count;

  int n_chk  = 0;
  int n_fail = 0;

  // model: queued bytes, frame in flight and cycle position within it
  logic [7:0]  q[$];
  logic        busy;
  int          pos;
  logic [7:0]  cur;
  logic [10:0] rx;

  uart_tx_fpga #(.clksPerBit(CPB), .fifoDepth(DEPTH)) dut (
    .i_clkTx     (clk),
    .i_resetN    (rst_n),
    .i_txValid   (tx_valid),
    .i_txByte    (tx_byte),
    .o_txReady   (tx_ready),
    .o_txBit     (tx_bit),
    .o_txActive  (tx_active),
    .o_txDone    (tx_done),
    .o_fifoCount (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] c, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return c[k-1];
    if (k == 9) return ^c;
    return 1'b1;
  endfunction

  // Called just after a falling edge; drives inputs, predicts the next rising edge, checks after it.
  task automatic step(input logic v, input logic [7:0] b);
    logic pop_m, rdy_m;
    tx_valid = v;
    tx_byte  = b;
    #1;
    pop_m = (q.size() > 0) && (!busy || pos == FRAME_LEN - 1);
    rdy_m = (q.size() < DEPTH) || pop_m;
    chk("ready", tx_ready, rdy_m);
    if (pop_m) begin
      cur  = q.pop_front();
      busy = 1'b1;
      pos  = 0;
    end else if (busy) begin
      pos++;
      if (pos == FRAME_LEN) busy = 1'b0;
    end
    if (v && rdy_m) q.push_back(b);
    @(posedge clk);
    @(negedge clk);
    chk("line",   tx_bit,    busy ? frame_bit(cur, pos / CPB) : 1'b1);
    chk("active", tx_active, busy);
    chk("done",   tx_done,   busy && pos == FRAME_LEN - 1);
    chk("count",  fifo_count, q.size());
    if (busy && pos % CPB == CPB / 2) rx[pos / CPB] = tx_bit;
    if (busy && pos == FRAME_LEN - 1) begin
      chk("rx_start", rx[0], 1'b0);
      chk("rx_data",  rx[8:1], cur);
      chk("rx_par",   rx[9], ^rx[8:1]);
      chk("rx_stop",  rx[10], 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    busy     = 1'b0;
    pos      = 0;
    cur      = 8'h00;
    rx       = '0;
    repeat (3) @(negedge clk);
    chk("rst_line",   tx_bit, 1'b1);
    chk("rst_active", tx_active, 1'b0);
    chk("rst_done",   tx_done, 1'b0);
    chk("rst_count",  fifo_count, 3'd0);
    chk("rst_ready",  tx_ready, 1'b1);
    rst_n = 1'b1;

    // single frames, including the parity corner bytes
    step(1'b1, 8'hA5); idle(50);
    step(1'b1, 8'h07); idle(46);
    step(1'b1, 8'h00); step(1'b1, 8'hFF); idle(100);

    // five back to back while idle: all accepted, frames contiguous
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
    idle(5 * FRAME_LEN + 10);

    // six back to back: the sixth hits a full FIFO and is dropped
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
    // hold valid so pushes land on the stop-end pop edges while full
    for (int i = 0; i < 150; i++) step(1'b1, 8'($urandom));
    idle(5 * FRAME_LEN + 10);

    // random traffic, bursty and sparse
    for (int i = 0; i < 3000; i++) begin
      if ((i / 300) % 2 == 0) step($urandom_range(0, 2) == 0, 8'($urandom));
      else                    step($urandom_range(0, 40) == 0, 8'($urandom));
    end
    idle(5 * FRAME_LEN + 10);

    // reset mid-DATA with bytes still queued
    step(1'b1, 8'h00); step(1'b1, 8'h3C); step(1'b1, 8'hC3);
    for (int i = 0; i < 20 && !(busy && pos == 14); i++) step(1'b0, 8'h00);
    chk("pre_rst_line", tx_bit, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_line",   tx_bit, 1'b1);
    chk("async_count",  fifo_count, 3'd0);
    chk("async_active", tx_active, 1'b0);
    chk("async_done",   tx_done, 1'b0);
    q.delete();
    busy = 1'b0;
    pos  = 0;
    repeat (2) @(negedge clk);
    chk("rst_hold_line", tx_bit, 1'b1);
    rst_n = 1'b1;
    idle(30);
    step(1'b1, 8'h5A); idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fpga.md
UART_TX_FPGA -- requirements
Module: uart_tx_fpga

Interface
REQ-001 Parameter clksPerBit, default 234, meaning clock cycles per serial bit; legal range 4..255.
REQ-002 Parameter fifoDepth, default 4, meaning transmit FIFO depth in bytes; power of two, 2..16.
REQ-003 i_clkTx  input  1  single clock; all logic rising-edge.
REQ-004 i_resetN  input  1  reset, asynchronous assert, active-low.
REQ-005 i_txValid  input  1  byte push request.
REQ-006 i_txByte  input  8  byte to transmit.
REQ-007 o_txReady  output  1  FIFO not full; push accepted when i_txValid and o_txReady.
REQ-008 o_txBit  output  1  serial line; idle high; feeds the matching receiver's i_txBit.
REQ-009 o_txActive  output  1  high while a frame is on the line.
REQ-010 o_txDone  output  1  one-cycle pulse at the end of each stop bit.
REQ-011 o_fifoCount  output  $clog2(fifoDepth)+1  bytes currently held in the FIFO.

Function
REQ-012 The frame SHALL be: start 0, data bits 0..7 LSB first, parity = XOR of data bits (even parity), stop 1; total 11*clksPerBit cycles.
REQ-013 Each bit SHALL be held on o_txBit for exactly clksPerBit cycles, timed by a bit counter running 0..clksPerBit-1.
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP; transitions occur only when the bit counter reaches clksPerBit-1, except IDLE.
REQ-015 IDLE: o_txBit=1, o_txActive=0; if the FIFO is non-empty, pop the head into a shift register, drive o_txBit=0, set o_txActive=1, go to START.
REQ-016 START->DATA; DATA shifts out 8 bits with a 3-bit index, ->PARITY after index 7; PARITY->STOP.
REQ-017 Parity SHALL be computed from the popped byte and held, so it is unaffected by later FIFO writes.
REQ-018 At the last STOP cycle o_txDone SHALL pulse for one cycle; if the FIFO is non-empty on that same edge, the next byte is popped and START begins with no idle gap; otherwise go to IDLE.
REQ-019 Latency: push sampled at edge E into an empty FIFO in IDLE -> o_txBit falls at edge E+1.
REQ-020 Push when o_txReady=0 SHALL be ignored; FIFO contents and count unchanged.
REQ-021 Simultaneous push and pop SHALL leave o_fifoCount unchanged; both are performed, including when the FIFO is full (pop frees the slot the push uses).
REQ-022 o_txReady SHALL be combinational: (count<fifoDepth) or pop this cycle.
REQ-023 FIFO pointers SHALL wrap modulo fifoDepth; count saturates at neither end because REQ-020 and REQ-021 prevent overflow and underflow.
REQ-024 Bytes SHALL be transmitted in push order.

Reset
REQ-025 On i_resetN low, immediately and asynchronously: state IDLE, o_txBit=1, o_txActive=0, o_txDone=0, o_fifoCount=0, counters 0, FIFO pointers 0.
REQ-026 Reset mid-frame SHALL abort the frame and discard all queued bytes; the line returns high without a partial stop bit.
REQ-027 After deassertion, no frame SHALL start until a new push.

Structure
REQ-028 The state encodings and the frame length constant (11 bits) SHALL live in a shared uart package used by both the tx and rx blocks.
REQ-029 The FIFO SHALL be a sub-module uart_tx_fifo (push, pop, head data, count, full, empty), instantiated once.

Verification
REQ-030 With clksPerBit=4, push 0xA5 -> line 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles; o_txDone pulses once at cycle 44.
REQ-031 Push 0x07 -> parity bit 1; loopback into the receiver with its reset = ~i_resetN -> o_rxBits=0x07, o_parityError=0.
REQ-032 Push 5 bytes back-to-back while idle with fifoDepth=4 -> 5 accepted (first pops at once); o_txReady low only while count=4 with no pop; frames are contiguous with no idle cycles; order preserved.
REQ-033 Push while full with no pop -> byte dropped; push while full on the STOP-end pop edge -> accepted and count stays 4.
REQ-034 Assert i_resetN low mid-DATA -> o_txBit=1 without waiting for a clock edge; o_fifoCount=0; no o_txDone pulse.
REQ-035 Push 0x00 then 0xFF -> parity bits 0 and 0, and the receiver reports no parity error for either frame.
